// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and frame constants
package uart_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with extra-MSB full/empty pointers
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  // The extra pointer MSB separates "wrapped once" (full) from "caught up" (empty).
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign empty = (r_wr_ptr == r_rd_ptr);

  // A push while full is dropped even if a pop frees a slot on the same edge.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  assign pop_data = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; natural binary wrap of the AW+1-bit pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Storage is written only on an accepted push, so idle bus values never land here.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with input FIFO
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);

  tx_state_t             r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_txd;
  logic                  r_busy;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_bit_end;
  logic [DATA_BITS-1:0]  w_pop_data;

  // Ready depends only on FIFO state, never on tx_valid.
  assign tx_ready  = !w_full;
  assign w_push    = tx_valid && !w_full;
  assign w_bit_end = (r_baud == BAUD_LAST);

  // Pop from IDLE as soon as a byte is visible, or at the end of STOP for a gapless next frame.
  assign w_pop = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  assign txd  = r_txd;
  assign busy = r_busy;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (w_push),
    .push_data (tx_data),
    .pop       (w_pop),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Frame sequencer: baud timing, LSB-first shifting and registered txd/busy.
  // busy is registered from the next-cycle view: a frame in flight next cycle,
  // or a byte being pushed now (which leaves the FIFO non-empty or is popped at once).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_busy <= 1'b1;
      case (r_state)
        IDLE: begin
          r_baud    <= '0;
          r_bit_idx <= '0;
          if (!w_empty) begin
            r_shift <= w_pop_data;
            r_txd   <= 1'b0;
            r_state <= START;
          end else begin
            r_txd  <= 1'b1;
            r_busy <= w_push;
          end
        end

        START: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_txd     <= r_shift[0];
            r_state   <= DATA;
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end

        DATA: begin
          if (w_bit_end) begin
            r_baud <= '0;
            if (r_bit_idx == IDX_LAST) begin
              r_txd   <= 1'b1;
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_ONE;
              r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
              r_txd     <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end

        STOP: begin
          if (w_bit_end) begin
            r_baud    <= '0;
            r_bit_idx <= '0;
            if (!w_empty) begin
              r_shift <= w_pop_data;
              r_txd   <= 1'b0;
              r_state <= START;
            end else begin
              r_txd   <= 1'b1;
              r_state <= IDLE;
              r_busy  <= w_push;
            end
          end else begin
            r_baud <= r_baud + BAUD_ONE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_txd   <= 1'b1;
          r_baud  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed and soak bench for uart_tx
`timescale 1ns/1ps
module tb_uart_tx;
  import uart_pkg::*;

  localparam int CPB       = 4;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_ready;
  logic       txd;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  logic [7:0] rx_q[$];
  int         rx_start_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    else if (j <= 8) return b[j-1];
    else return 1'b1;
  endfunction

  // Reference receiver: hunts for a low, then samples mid-bit on every CPB-th negedge.
  int         rx_phase = 0;
  int         rx_off   = 0;
  int         rx_t0    = 0;
  logic [7:0] rx_byte  = 8'h00;
  always @(negedge clk) begin
    if (!reset_n) begin
      rx_phase = 0;
    end else if (rx_phase == 0) begin
      if (txd === 1'b0) begin
        rx_phase = 1;
        rx_off   = 0;
        rx_t0    = cyc;
      end
    end else begin
      rx_off++;
      if (rx_off % CPB == CPB / 2) begin
        if (rx_off / CPB == 0) begin
          check("rx_start_bit", {31'd0, txd}, 32'd0);
          if (txd !== 1'b0) rx_phase = 0;
        end else if (rx_off / CPB <= 8) begin
          rx_byte[rx_off / CPB - 1] = txd;
        end else begin
          check("rx_stop_bit", {31'd0, txd}, 32'd1);
          rx_q.push_back(rx_byte);
          rx_start_q.push_back(rx_t0);
          rx_phase = 0;
        end
      end
    end
  end

  a_hold: assert property (@(posedge clk) disable iff (!reset_n)
                           (tx_valid && !tx_ready) |=> (tx_valid && $stable(tx_data)))
    else begin
      n_errors++;
      $display("FAIL tx_hold: tx_data changed while stalled, required stable");
    end

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] b, output int e0);
    check("send_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    e0       = cyc;
    tx_valid = 1'b0;
    tx_data  = 8'hxx;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && rx_q.size() < n; c++) @(negedge clk);
    check(tag, rx_q.size(), n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int c = 0; c < budget && busy; c++) @(negedge clk);
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic expect_rx(input string tag, input int idx, input logic [7:0] b);
    if (idx < rx_q.size()) check(tag, {24'd0, rx_q[idx]}, {24'd0, b});
    else check(tag, 32'hdead, {24'd0, b});
  endtask

  initial begin
    int         e0;
    int         lows;
    int         idx;
    int         gap;
    logic       r;
    int         acc[$];
    logic [7:0] exp_q[$];
    int         off_exp[6];

    // Reset held with tx_valid high: idle outputs, nothing accepted.
    reset_n  = 1'b0;
    tx_valid = 1'b1;
    tx_data  = 8'h77;
    repeat (3) begin
      @(negedge clk);
      check("rst_txd", {31'd0, txd}, 32'd1);
      check("rst_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    reset_n  = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    check("post_rst_txd", {31'd0, txd}, 32'd1);

    // Single byte 0x55: bit-exact waveform from E1, busy falls at E1+40.
    rx_q.delete();
    rx_start_q.delete();
    align();
    send_one(8'h55, e0);
    @(negedge clk);
    check("sb_pre_txd", {31'd0, txd}, 32'd1);
    check("sb_pre_busy", {31'd0, busy}, 32'd1);
    for (int t = 0; t < FRAME_CYC; t++) begin
      @(negedge clk);
      check("sb_txd", {31'd0, txd}, {31'd0, frame_bit(8'h55, t / CPB)});
      check("sb_busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("sb_busy_end", {31'd0, busy}, 32'd0);
    check("sb_txd_end", {31'd0, txd}, 32'd1);
    wait_rx("sb_rx_count", 1, 4 * CPB);
    expect_rx("sb_rx_byte", 0, 8'h55);
    if (rx_start_q.size() > 0) check("sb_start_cyc", rx_start_q[0], e0 + 1);

    // Back-to-back: second start exactly one frame after the first.
    rx_q.delete();
    rx_start_q.delete();
    align();
    check("b2b_ready", {31'd0, tx_ready}, 32'd1);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    e0      = cyc;
    tx_data = 8'h3C;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'hxx;
    wait_rx("b2b_rx_count", 2, 3 * FRAME_CYC);
    expect_rx("b2b_byte0", 0, 8'hA5);
    expect_rx("b2b_byte1", 1, 8'h3C);
    if (rx_start_q.size() == 2) begin
      check("b2b_start0", rx_start_q[0], e0 + 1);
      check("b2b_gap", rx_start_q[1] - rx_start_q[0], FRAME_CYC);
    end
    wait_idle("b2b_idle", 2 * FRAME_CYC);

    // FIFO full: 0x01..0x06 held on the bus; sixth accepted the cycle after 0x02's pop.
    rx_q.delete();
    rx_start_q.delete();
    acc.delete();
    align();
    idx      = 1;
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    for (int c = 0; c < 400 && idx <= 6; c++) begin
      r = tx_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc.push_back(cyc);
        idx++;
        if (idx <= 6) tx_data = 8'(idx);
        else begin
          tx_valid = 1'b0;
          tx_data  = 8'hxx;
        end
        if (acc.size() == 5) check("ff_ready_drop", {31'd0, tx_ready}, 32'd0);
      end
    end
    tx_valid = 1'b0;
    check("ff_accept_count", acc.size(), 6);
    off_exp = '{0, 1, 2, 3, 4, FRAME_CYC + 2};
    if (acc.size() == 6)
      for (int k = 1; k < 6; k++) check("ff_accept_cyc", acc[k] - acc[0], off_exp[k]);
    wait_rx("ff_rx_count", 6, 8 * FRAME_CYC);
    for (int k = 0; k < 6; k++) expect_rx("ff_byte", k, 8'(k + 1));
    if (rx_start_q.size() == 6 && acc.size() == 6) begin
      check("ff_first_start", rx_start_q[0], acc[0] + 1);
      for (int k = 1; k < 6; k++) check("ff_gap", rx_start_q[k] - rx_start_q[k-1], FRAME_CYC);
    end
    wait_idle("ff_idle", 2 * FRAME_CYC);

    // Reset during data bit 3 of 0xFF: outputs snap to idle, nothing resumes.
    align();
    send_one(8'hFF, e0);
    for (int c = 0; c < 100 && cyc < e0 + 1 + 4 * CPB + 1; c++) begin
      @(posedge clk);
      #1;
    end
    #2;
    check("mr_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("mr_txd", {31'd0, txd}, 32'd1);
    check("mr_busy", {31'd0, busy}, 32'd0);
    check("mr_ready", {31'd0, tx_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    rx_q.delete();
    rx_start_q.delete();
    lows = 0;
    for (int c = 0; c < 2 * FRAME_CYC; c++) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("mr_no_residual", lows, 0);
    check("mr_ready_after", {31'd0, tx_ready}, 32'd1);
    check("mr_rx_empty", rx_q.size(), 0);

    // Random soak with gaps, checked against the reference receiver.
    rx_q.delete();
    rx_start_q.delete();
    exp_q.delete();
    align();
    for (int i = 0; i < 200; i++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) align();
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      r        = 1'b0;
      for (int c = 0; c < 4 * FRAME_CYC && !r; c++) begin
        r = tx_ready;
        @(posedge clk);
        #1;
      end
      if (!r) check("soak_accept", 32'd0, 32'd1);
      exp_q.push_back(tx_data);
      tx_valid = 1'b0;
      tx_data  = 8'hxx;
    end
    wait_rx("soak_rx_count", 200, 10 * FRAME_CYC);
    for (int i = 0; i < 200; i++) expect_rx("soak_byte", i, exp_q[i]);
    wait_idle("soak_idle", 2 * FRAME_CYC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter driving the top-level txd pin; the transmit-direction counterpart of the rxd receive path.
- Accepts bytes over a valid/ready handshake from the core-side bus glue.
- Buffers them in a small synchronous FIFO and serialises each byte LSB-first at a fixed baud derived from the system clock.

Parameters:
- CLKS_PER_BIT, 234, clock cycles per serial bit (27 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 4, byte entries in the input FIFO; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- tx_data  input  8  byte to send; sampled on the accepting edge.
- tx_valid  input  1  tx_data is valid; source holds tx_data and tx_valid until accepted.
- tx_ready  output  1  FIFO can accept; high when FIFO not full.
- txd  output  1  serial line, registered, idle high.
- busy  output  1  high while the FIFO is non-empty or a frame is in flight.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - txd=1, tx_ready=1, busy=0.
  - FIFO emptied, FSM in IDLE, bit counter and baud counter cleared.
- Handshake:
  - Transfer occurs on a rising edge with tx_valid && tx_ready.
  - tx_ready = !fifo_full; it has no combinational path from tx_valid.
  - No push while full, even if a pop occurs on the same edge.
- FSM states:
  - IDLE: txd=1. If FIFO non-empty, pop the head into shift register, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit_idx=7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles. At the end, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Latency:
  - Byte accepted at edge E0 into an empty FIFO with FSM in IDLE: FSM pops at E1, txd low from E1.
  - Frame = 10*CLKS_PER_BIT cycles; txd back high at E1+9*CLKS_PER_BIT (stop bit start).
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads at each bit boundary; width $clog2(CLKS_PER_BIT).
- FIFO:
  - Read/write pointers are $clog2(FIFO_DEPTH)+1 bits wide; wrap-around is natural.
  - full when the addresses are equal and the MSBs differ; empty when the pointers are equal.
  - Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
  - Push into an empty FIFO while the FSM is in IDLE: the byte is visible to the FSM on the next edge; no same-cycle bypass.
- busy = (state != IDLE) || !fifo_empty; registered or combinational from registers, but glitch-free at the pin.
- Reset mid-frame: txd returns to 1 immediately and the frame is abandoned; no resume after release.
- tx_data is ignored when tx_valid=0; X on tx_data with tx_valid=0 must not propagate to any register.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, START, DATA, STOP}.
  - localparam DATA_BITS=8, FRAME_BITS=10.
  - Shared later by the receive side.
- Sub-module sync_fifo:
  - Parameters WIDTH, DEPTH.
  - Ports clk, reset_n, push, push_data, pop, pop_data, full, empty.
  - Reusable for the future receiver.
- uart_tx contains the FSM, baud counter and shift register.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with tx_valid=1 -> txd=1, tx_ready=1, busy=0 throughout; no byte accepted.
- Single byte (CLKS_PER_BIT=4): send 0x55 at E0 -> txd low from E1 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, then stop high 4 cycles; busy falls at E1+40; sampled byte 0x55.
- Back-to-back: send 0xA5 then 0x3C on consecutive cycles -> second start bit begins exactly 10*CLKS_PER_BIT cycles after the first, with no idle high beyond the stop bit; decoded 0xA5, 0x3C.
- FIFO full (FIFO_DEPTH=4): hold tx_valid with bytes 0x01..0x06 -> 0x01 popped at E1; 0x02..0x05 fill the FIFO and tx_ready drops after the 5th accept; 0x06 accepted on the cycle after the STOP→START pop of 0x02; all six are emitted in order.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 of 0xFF -> txd=1 asynchronously; after release busy=0, tx_ready=1, and no residual frame is emitted.
- Random soak: 200 random bytes with random tx_valid gaps, checked by a bit-level reference receiver -> zero mismatches; tx_data stable whenever tx_valid && !tx_ready (assertion).
